// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and default widths for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned IfqDefInstW = 32;
    localparam int unsigned IfqDefAddrW = 32;

    typedef enum logic [1:0] {
        IfqIdle = 2'd0,
        IfqReq  = 2'd1,
        IfqWait = 2'd2,
        IfqDrop = 2'd3
    } ifq_state_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Fetch queue storage: DEPTH entries of WIDTH bits with push, pop and synchronous clear.
module inst_fetch_queue_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 65
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetcher: owns the PC, issues one fetch at a time, queues inst+PC+prediction for dispatch.
// Define IFQ_BYPASS_EN to forward a response straight to dispatch when the queue is empty.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned       ADDR_W      = IfqDefAddrW,
    parameter int unsigned       INST_W      = IfqDefInstW,
    parameter int unsigned       QUEUE_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              MC_fetch_valid,
    output logic [ADDR_W-1:0] MC_fetch_addr,
    input  logic              MC_fetch_ready,
    input  logic              MC_input_valid,
    input  logic [INST_W-1:0] MC_inst,
    output logic [INST_W-1:0] PDC_inst,
    output logic [ADDR_W-1:0] PDC_pc,
    input  logic              PDC_need_jump,
    input  logic [ADDR_W-1:0] PDC_jumped_pc,
    input  logic              ROB_flush,
    input  logic [ADDR_W-1:0] ROB_target_pc,
    output logic              DSP_valid,
    input  logic              DSP_ready,
    output logic [INST_W-1:0] DSP_inst,
    output logic [ADDR_W-1:0] DSP_pc,
    output logic              DSP_pred_jump
);

    localparam int unsigned EntryW = INST_W + ADDR_W + 1;

    ifq_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;

    logic              w_resp;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_clear;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [EntryW-1:0] w_head;

    assign w_resp = (r_state == IfqWait) && MC_input_valid;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = rdy && w_resp && w_fifo_empty && DSP_ready && !ROB_flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_clear = rdy && ROB_flush;
    assign w_push  = rdy && !ROB_flush && w_resp && !w_bypass;
    assign w_pop   = rdy && !ROB_flush && DSP_ready && !w_fifo_empty;

    inst_fetch_queue_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_wdata ({MC_inst, r_pc, PDC_need_jump}),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IfqIdle;
            r_pc    <= RESET_PC;
        end else if (rdy) begin
            if (ROB_flush) begin
                r_pc <= ROB_target_pc;
                case (r_state)
                    IfqIdle: r_state <= IfqIdle;
                    IfqReq:  r_state <= MC_fetch_ready ? IfqDrop : IfqIdle;
                    // A response arriving with the flush retires the outstanding request.
                    IfqWait: r_state <= MC_input_valid ? IfqIdle : IfqDrop;
                    IfqDrop: r_state <= MC_input_valid ? IfqIdle : IfqDrop;
                    default: r_state <= IfqIdle;
                endcase
            end else begin
                case (r_state)
                    IfqIdle: if (!w_fifo_full) r_state <= IfqReq;
                    IfqReq:  if (MC_fetch_ready) r_state <= IfqWait;
                    IfqWait: begin
                        if (MC_input_valid) begin
                            r_pc    <= PDC_need_jump ? PDC_jumped_pc : r_pc + ADDR_W'(4);
                            r_state <= IfqIdle;
                        end
                    end
                    IfqDrop: if (MC_input_valid) r_state <= IfqIdle;
                    default: r_state <= IfqIdle;
                endcase
            end
        end
    end

    assign MC_fetch_valid = (r_state == IfqReq);
    assign MC_fetch_addr  = r_pc;
    assign PDC_inst       = MC_inst;
    assign PDC_pc         = r_pc;

    // Data outputs are zeroed when invalid so stale or flushed entries never show.
    always_comb begin
        DSP_valid     = 1'b0;
        DSP_inst      = '0;
        DSP_pc        = '0;
        DSP_pred_jump = 1'b0;
        if (w_bypass) begin
            DSP_valid     = 1'b1;
            DSP_inst      = MC_inst;
            DSP_pc        = r_pc;
            DSP_pred_jump = PDC_need_jump;
        end else if (!w_fifo_empty) begin
            DSP_valid     = 1'b1;
            DSP_inst      = w_head[EntryW-1 -: INST_W];
            DSP_pc        = w_head[ADDR_W:1];
            DSP_pred_jump = w_head[0];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default build, queue depth 8).
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        MC_fetch_valid;
    logic [31:0] MC_fetch_addr;
    logic        MC_fetch_ready;
    logic        MC_input_valid;
    logic [31:0] MC_inst;
    logic [31:0] PDC_inst;
    logic [31:0] PDC_pc;
    logic        PDC_need_jump;
    logic [31:0] PDC_jumped_pc;
    logic        ROB_flush;
    logic [31:0] ROB_target_pc;
    logic        DSP_valid;
    logic        DSP_ready;
    logic [31:0] DSP_inst;
    logic [31:0] DSP_pc;
    logic        DSP_pred_jump;

    int n_total = 0;
    int n_bad   = 0;

    inst_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .MC_fetch_valid (MC_fetch_valid),
        .MC_fetch_addr  (MC_fetch_addr),
        .MC_fetch_ready (MC_fetch_ready),
        .MC_input_valid (MC_input_valid),
        .MC_inst        (MC_inst),
        .PDC_inst       (PDC_inst),
        .PDC_pc         (PDC_pc),
        .PDC_need_jump  (PDC_need_jump),
        .PDC_jumped_pc  (PDC_jumped_pc),
        .ROB_flush      (ROB_flush),
        .ROB_target_pc  (ROB_target_pc),
        .DSP_valid      (DSP_valid),
        .DSP_ready      (DSP_ready),
        .DSP_inst       (DSP_inst),
        .DSP_pc         (DSP_pc),
        .DSP_pred_jump  (DSP_pred_jump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Acts as the memory controller for one fetch: accept, then answer one cycle later.
    task automatic serve(input logic [31:0] inst, input logic jump, input logic [31:0] tgt,
                         input logic [31:0] addr);
        int n = 0;
        while (!MC_fetch_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_valid", {31'd0, MC_fetch_valid}, 32'd1);
        chk("fetch_addr", MC_fetch_addr, addr);
        MC_fetch_ready = 1'b1;
        @(negedge clk);
        MC_fetch_ready = 1'b0;
        MC_input_valid = 1'b1;
        MC_inst        = inst;
        PDC_need_jump  = jump;
        PDC_jumped_pc  = tgt;
        #1;
        chk("pdc_pc", PDC_pc, addr);
        chk("pdc_inst", PDC_inst, inst);
        @(negedge clk);
        MC_input_valid = 1'b0;
        PDC_need_jump  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        MC_fetch_ready = 1'b0; MC_input_valid = 1'b0; MC_inst = '0;
        PDC_need_jump = 1'b0; PDC_jumped_pc = '0;
        ROB_flush = 1'b0; ROB_target_pc = '0; DSP_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_fetch_valid", {31'd0, MC_fetch_valid}, 32'd0);
        chk("rst_fetch_addr", MC_fetch_addr, 32'h0);
        chk("rst_dsp_valid", {31'd0, DSP_valid}, 32'd0);
        chk("rst_dsp_pc", DSP_pc, 32'h0);
        rst = 1'b1;

        // In-order stream 0,4,8,12 with dispatch always ready.
        for (int i = 0; i < 4; i++) begin
            serve(32'hA000_0000 + 32'(i), 1'b0, 32'h0, 32'(4 * i));
            chk("seq_valid", {31'd0, DSP_valid}, 32'd1);
            chk("seq_pc", DSP_pc, 32'(4 * i));
            chk("seq_inst", DSP_inst, 32'hA000_0000 + 32'(i));
        end

        // Predicted-taken at 0x10 towards 0x100.
        serve(32'hA100_0000, 1'b1, 32'h100, 32'h10);
        chk("jump_pc", DSP_pc, 32'h10);
        chk("jump_pred", {31'd0, DSP_pred_jump}, 32'd1);
        @(negedge clk);

        // Fill all 8 slots with dispatch stalled.
        DSP_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serve(32'hB000_0000 + 32'(i), 1'b0, 32'h0, 32'h100 + 32'(4 * i));
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("full_no_fetch", {31'd0, MC_fetch_valid}, 32'd0);
        end
        chk("full_head_pc", DSP_pc, 32'h100);
        DSP_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_pc", DSP_pc, 32'h100 + 32'(4 * k));
            chk("drain_inst", DSP_inst, 32'hB000_0000 + 32'(k));
            @(negedge clk);
        end
        chk("drain_empty", {31'd0, DSP_valid}, 32'd0);
        chk("resume_valid", {31'd0, MC_fetch_valid}, 32'd1);
        chk("resume_addr", MC_fetch_addr, 32'h120);

        // Flush while waiting; the late response must be dropped.
        MC_fetch_ready = 1'b1;
        @(negedge clk);
        MC_fetch_ready = 1'b0;
        ROB_flush = 1'b1; ROB_target_pc = 32'h200;
        @(negedge clk);
        ROB_flush = 1'b0;
        chk("drop_no_fetch", {31'd0, MC_fetch_valid}, 32'd0);
        MC_input_valid = 1'b1; MC_inst = 32'hDEAD_BEEF;
        PDC_need_jump = 1'b1; PDC_jumped_pc = 32'h999;
        @(negedge clk);
        MC_input_valid = 1'b0; PDC_need_jump = 1'b0;
        chk("drop_dsp_valid", {31'd0, DSP_valid}, 32'd0);
        serve(32'hC000_0000, 1'b0, 32'h0, 32'h200);
        chk("flush_first_pc", DSP_pc, 32'h200);
        chk("flush_first_inst", DSP_inst, 32'hC000_0000);
        @(negedge clk);

        // Three queued, then flush on the same edge as a push and a pop.
        DSP_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serve(32'hD000_0000 + 32'(i), 1'b0, 32'h0, 32'h204 + 32'(4 * i));
        end
        chk("cnt3_head", DSP_pc, 32'h204);
        serve_flush_edge();
        chk("flush_clear_valid", {31'd0, DSP_valid}, 32'd0);

        // Frozen for 5 cycles: no move to REQ, PC kept.
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("frz_fetch_valid", {31'd0, MC_fetch_valid}, 32'd0);
            chk("frz_fetch_addr", MC_fetch_addr, 32'h300);
        end
        rdy = 1'b1;
        serve(32'hE000_0000, 1'b0, 32'h0, 32'h300);
        chk("post_frz_pc", DSP_pc, 32'h300);

        // PC wrap at the top of the address space.
        ROB_flush = 1'b1; ROB_target_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        ROB_flush = 1'b0;
        chk("wrap_flush_valid", {31'd0, DSP_valid}, 32'd0);
        serve(32'hF000_0000, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_top_pc", DSP_pc, 32'hFFFF_FFFC);
        serve(32'hF000_0001, 1'b0, 32'h0, 32'h0);
        chk("wrap_zero_pc", DSP_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Fourth fetch at 0x210 answered with dispatch ready and a flush to 0x300 on one edge.
    task automatic serve_flush_edge();
        int n = 0;
        while (!MC_fetch_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fe_fetch_addr", MC_fetch_addr, 32'h210);
        MC_fetch_ready = 1'b1;
        @(negedge clk);
        MC_fetch_ready = 1'b0;
        MC_input_valid = 1'b1; MC_inst = 32'hD000_0003;
        DSP_ready = 1'b1;
        ROB_flush = 1'b1; ROB_target_pc = 32'h300;
        @(negedge clk);
        MC_input_valid = 1'b0;
        ROB_flush = 1'b0;
    endtask

endmodule
